sim_fetch_seq: RTL and testbench



---
 rtl/sim_intf_pkg.sv | 26 ++
 rtl/sim_fetch_fifo.sv | 68 ++++++
 rtl/sim_fetch_seq.sv | 132 +++++++++++++
 tb/tb_sim_fetch_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_intf_pkg.sv
// Shared types for the ISS co-simulation fetch path: widths, FSM states,
// FIFO entry layout and the sequential next-PC rule.
package sim_intf_pkg;

    localparam int unsigned PC_W   = 64;
    localparam int unsigned INST_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CHK  = 2'd2,
        ERR  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_ent_t;

    // Compressed (16-bit) encodings have inst[1:0] != 2'b11.
    function automatic logic [PC_W-1:0] next_pc(input logic [PC_W-1:0]   pc,
                                                 input logic [INST_W-1:0] inst);
        return pc + ((inst[1:0] == 2'b11) ? PC_W'(4) : PC_W'(2));
    endfunction

endpackage

// File: rtl/sim_fetch_fifo.sv
// Synchronous FIFO of confirmed fetch entries with a registered head value.
module sim_fetch_fifo
    import sim_intf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  fetch_ent_t             push_data,
    input  logic                   pop,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output fetch_ent_t             head
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_ent_t       mem_q [DEPTH];
    fetch_ent_t       head_q, head_d;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, left_c;
    logic             push_ok_c, pop_ok_c;

    // Pointer/count update and next head value, bypassing the write when the
    // pushed entry becomes the head in the same cycle.
    always_comb begin
        push_ok_c = push && (cnt_q != CNT_W'(DEPTH));
        pop_ok_c  = pop && (cnt_q != '0);
        wr_d      = wr_q + PTR_W'(push_ok_c);
        rd_d      = rd_q + PTR_W'(pop_ok_c);
        cnt_d     = cnt_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
        left_c    = cnt_q - CNT_W'(pop_ok_c);
        head_d    = head_q;
        if (cnt_d != '0) begin
            head_d = (left_c == '0) ? push_data : mem_q[rd_d];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clr && push_ok_c) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign head  = head_q;

endmodule

// File: rtl/sim_fetch_seq.sv
// Fetch-PC sequencer in front of sim_intf: one request in flight, redirect on
// miss, buffer confirmed (pc, inst) pairs, count misses and flag runaway.
module sim_fetch_seq
    import sim_intf_pkg::*;
#(
    parameter logic [PC_W-1:0] START_PC   = 64'h0000_0000_0000_1000,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter int unsigned     MISS_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic [PC_W-1:0]   flush_pc,
    output logic [PC_W-1:0]   sim_pc_try,
    input  logic [PC_W-1:0]   sim_pc_factual,
    input  logic [INST_W-1:0] sim_inst,
    input  logic              sim_miss,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [31:0]       miss_cnt,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d, try_q, try_d;
    logic [31:0]      miss_q, miss_d, run_q, run_d;
    logic             err_q, err_d;
    logic             push_c, pop_c;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_cnt;
    fetch_ent_t       push_ent, head_ent;

    assign push_ent = '{pc: pc_q, inst: sim_inst};
    assign pop_c    = out_valid && out_ready;

    // Next-state and datapath decisions; flush overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        try_d   = try_q;
        miss_d  = miss_q;
        run_d   = run_q;
        err_d   = err_q;
        push_c  = 1'b0;
        if (flush) begin
            state_d = IDLE;
            pc_d    = flush_pc;
            run_d   = '0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && (fifo_cnt < CNT_W'(FIFO_DEPTH))) begin
                        state_d = REQ;
                        try_d   = pc_q;
                    end
                end
                REQ: state_d = CHK;
                CHK: begin
                    if (!sim_miss) begin
                        push_c  = !fifo_full;
                        pc_d    = next_pc(pc_q, sim_inst);
                        run_d   = '0;
                        state_d = IDLE;
                    end else begin
                        pc_d  = sim_pc_factual;
                        run_d = run_q + 32'd1;
                        if (miss_q != '1) begin
                            miss_d = miss_q + 32'd1;
                        end
                        // Retry keeps the reserved FIFO slot, so it skips IDLE.
                        if (run_q + 32'd1 > 32'(MISS_LIMIT)) begin
                            state_d = ERR;
                            err_d   = 1'b1;
                        end else begin
                            state_d = REQ;
                            try_d   = sim_pc_factual;
                        end
                    end
                end
                ERR:     state_d = ERR;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= START_PC;
            try_q   <= START_PC;
            miss_q  <= '0;
            run_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            try_q   <= try_d;
            miss_q  <= miss_d;
            run_q   <= run_d;
            err_q   <= err_d;
        end
    end

    sim_fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .push      (push_c),
        .push_data (push_ent),
        .pop       (pop_c),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt),
        .head      (head_ent)
    );

    assign sim_pc_try = try_q;
    assign out_valid  = !fifo_empty;
    assign out_pc     = head_ent.pc;
    assign out_inst   = head_ent.inst;
    assign miss_cnt   = miss_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sim_fetch_seq.sv
// Bench for sim_fetch_seq: an ISS stand-in plus a transaction-level model of
// the fetch rules, driven by directed scenarios then random traffic.
module tb_sim_fetch_seq;

    localparam logic [63:0] START = 64'h1000;
    localparam int          DEPTH = 4;
    localparam int          LIMIT = 3;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n, en, flush, out_ready;
    logic [63:0] flush_pc, sim_pc_factual;
    logic [31:0] sim_inst;
    logic        sim_miss;
    logic [63:0] sim_pc_try, out_pc;
    logic [31:0] out_inst, miss_cnt;
    logic        out_valid, err;

    always #5 clk = ~clk;

    sim_fetch_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .flush          (flush),
        .flush_pc       (flush_pc),
        .sim_pc_try     (sim_pc_try),
        .sim_pc_factual (sim_pc_factual),
        .sim_inst       (sim_inst),
        .sim_miss       (sim_miss),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .miss_cnt       (miss_cnt),
        .err            (err)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ISS stand-in: true program counter, instruction memory, fault modes.
    logic [63:0] iss_pc     = START;
    logic [63:0] alias_mask = '1;
    bit          iss_bad    = 1'b0;
    bit          jumps      = 1'b0;
    int          imem_mode  = 0;

    // Reference model: phase 0 waiting, 1 asking, 2 answer due, 3 halted.
    int          m_phase = 0;
    logic [63:0] m_pc    = START;
    logic [63:0] m_try   = START;
    ent_t        m_q[$];
    logic [31:0] m_miss  = '0;
    int          m_run   = 0;
    bit          m_err   = 1'b0;

    logic [63:0] seen[$];

    function automatic logic [31:0] imem(input logic [63:0] pc);
        logic [31:0] h;
        if (imem_mode == 0) return (pc == 64'h100C) ? 32'h0000_4501 : 32'h0000_0013;
        h = (pc[31:0] * 32'h9E37_79B1) ^ pc[63:32];
        return h ^ (h >> 15);
    endfunction

    function automatic logic [63:0] rnd_even();
        logic [63:0] v;
        if ($urandom % 8 == 0) v = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
        else v = {$urandom, $urandom};
        return v & ~64'h1;
    endfunction

    function automatic logic [63:0] seq_pc(input logic [63:0] pc, input logic [31:0] inst);
        return ((inst & 32'h3) == 32'h3) ? pc + 64'd4 : pc + 64'd2;
    endfunction

    task automatic model_update();
        int cnt0;
        cnt0 = m_q.size();
        if (!rst_n) begin
            m_phase = 0; m_pc = START; m_try = START;
            m_q.delete(); m_miss = '0; m_run = 0; m_err = 1'b0;
        end else if (flush) begin
            m_phase = 0; m_pc = flush_pc; m_q.delete(); m_run = 0; m_err = 1'b0;
        end else begin
            if (cnt0 > 0 && out_ready) void'(m_q.pop_front());
            case (m_phase)
                0: if (en && cnt0 < DEPTH) begin m_phase = 1; m_try = m_pc; end
                1: m_phase = 2;
                2: begin
                    if (!sim_miss) begin
                        m_q.push_back('{pc: m_pc, inst: sim_inst});
                        m_pc = seq_pc(m_pc, sim_inst);
                        m_run = 0;
                        m_phase = 0;
                    end else begin
                        m_pc = sim_pc_factual;
                        if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 32'd1;
                        m_run++;
                        if (m_run > LIMIT) begin m_phase = 3; m_err = 1'b1; end
                        else begin m_phase = 1; m_try = sim_pc_factual; end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic iss_update(input bit hit, input logic [31:0] inst);
        if (!rst_n) begin
            iss_pc = START; iss_bad = 1'b0;
        end else if (flush) begin
            iss_pc = flush_pc & alias_mask; iss_bad = 1'b0;
        end else if (hit) begin
            iss_pc = (jumps && $urandom % 5 == 0) ? rnd_even() : seq_pc(iss_pc, inst);
        end
    endtask

    // One clock: ISS answers, edge, model advances, outputs compared.
    task automatic step();
        bit in_chk;
        in_chk = (m_phase == 2);
        if (in_chk && iss_bad) begin
            sim_miss = 1'b1; sim_pc_factual = rnd_even(); sim_inst = $urandom;
        end else if (in_chk && m_try == iss_pc) begin
            sim_miss = 1'b0; sim_pc_factual = {$urandom, $urandom}; sim_inst = imem(m_try);
        end else if (in_chk) begin
            sim_miss = 1'b1; sim_pc_factual = iss_pc; sim_inst = $urandom;
        end else begin
            sim_miss = 1'($urandom); sim_pc_factual = {$urandom, $urandom}; sim_inst = $urandom;
        end
        if (out_valid === 1'b1 && out_ready) seen.push_back(out_pc);
        @(posedge clk);
        model_update();
        iss_update(in_chk && !sim_miss, sim_inst);
        #1;
        check("pc_try", sim_pc_try, m_try);
        check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("out_pc", out_pc, m_q[0].pc);
            check("out_inst", 64'(out_inst), 64'(m_q[0].inst));
        end
        check("miss_cnt", 64'(miss_cnt), 64'(m_miss));
        check("err", 64'(err), 64'(m_err));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_chk();
        for (int k = 0; k < 12 && m_phase != 2; k++) step();
        check("wait_chk", 64'(m_phase), 64'd2);
    endtask

    task automatic check_seen(input string tag, input logic [63:0] exp[4]);
        check({tag, "_n"}, 64'(seen.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < seen.size(); i++) check(tag, seen[i], exp[i]);
    endtask

    initial begin
        logic [63:0] exp4[4];
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; flush_pc = '0; out_ready = 1'b1;
        sim_miss = 1'b0; sim_pc_factual = '0; sim_inst = '0;
        steps(2);
        rst_n = 1'b1;
        check("rst_pc_try", sim_pc_try, 64'h1000);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_miss", 64'(miss_cnt), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        steps(2);

        // Sequential trace including a compressed instruction at 0x100C.
        seen.delete();
        en = 1'b1;
        steps(20);
        exp4 = '{64'h1000, 64'h1004, 64'h1008, 64'h100C};
        check_seen("seq", exp4);
        check("seq_c", seen.size() > 4 ? seen[4] : 64'hX, 64'h100E);
        en = 1'b0;
        steps(6);

        // Wrong PC: the ISS aliases 0xAAAA1008 to 0x1008.
        alias_mask = 64'hFFFF; flush = 1'b1; flush_pc = 64'hAAAA_1008; en = 1'b1;
        step();
        flush = 1'b0; alias_mask = '1;
        seen.delete();
        steps(3);
        check("miss_redirect", sim_pc_try, 64'h1008);
        check("miss_one", 64'(miss_cnt), 64'd1);
        steps(6);
        check("miss_first_out", seen.size() > 0 ? seen[0] : 64'hX, 64'h1008);

        // Back-pressure: fill, hold, then drain in order.
        flush = 1'b1; flush_pc = 64'h1000; out_ready = 1'b0;
        step();
        flush = 1'b0;
        steps(20);
        check("full_hold_try", sim_pc_try, 64'h100C);
        check("full_head", out_pc, 64'h1000);
        out_ready = 1'b1;
        seen.delete();
        steps(12);
        check_seen("drain", exp4);

        // Runaway divergence, then recovery by flush.
        iss_bad = 1'b1;
        steps(14);
        check("runaway_err", 64'(err), 64'd1);
        check("runaway_miss", 64'(miss_cnt), 64'd5);
        iss_bad = 1'b0; flush = 1'b1; flush_pc = 64'h2000;
        step();
        flush = 1'b0;
        check("flush_err_clr", 64'(err), 64'd0);
        step();
        check("flush_req", sim_pc_try, 64'h2000);
        check("flush_keep_miss", 64'(miss_cnt), 64'd5);

        // Flush and reset landing on the response cycle.
        wait_chk();
        flush = 1'b1; flush_pc = 64'h3000;
        step();
        flush = 1'b0;
        check("chk_flush_nopush", 64'(out_valid), 64'd0);
        wait_chk();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("chk_rst_try", sim_pc_try, 64'h1000);
        check("chk_rst_empty", 64'(out_valid), 64'd0);

        // Random traffic against the model.
        imem_mode = 1; jumps = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            rst_n     = ($urandom % 500) != 0;
            flush     = ($urandom % 60) == 0;
            flush_pc  = rnd_even();
            en        = ($urandom % 5) != 0;
            out_ready = ($urandom % 5) < 3;
            if ($urandom % 200 == 0) iss_bad = 1'b1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
